// File: rtl/ula_pkg.sv
// Shared encodings for the sign-magnitude arithmetic unit.
// Operation codes and sequencer states.
package ula_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ADD  = 2'b01,
    S_MUL  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/sm_add.sv
// Combinational sign-magnitude adder.
// Result never carries a negative zero.
module sm_add #(
  parameter int W = 29
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sign_a,
  input  logic         sign_b,
  output logic [W-1:0] c,
  output logic         sign_c
);

  // like signs add; unlike signs subtract smaller from larger
  always_comb begin
    c      = '0;
    sign_c = 1'b0;
    if (sign_a == sign_b) begin
      c      = a + b;
      sign_c = sign_a;
    end else if (a >= b) begin
      c      = a - b;
      sign_c = sign_a;
    end else begin
      c      = b - a;
      sign_c = sign_b;
    end
    if (c == '0) sign_c = 1'b0;
  end

endmodule

// File: rtl/ula_param.sv
// Sequenced add/sub/mul unit on sign-magnitude operands.
// ULA_PARAM_RADIX4_EN: multiply retires two multiplier bits per cycle.
module ula_param
  import ula_pkg::*;
#(
  parameter  int MANT_W = 24,
  parameter  int GRD_W  = 3,
  localparam int W      = MANT_W + GRD_W + 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sign_a,
  input  logic         sign_b,
  input  logic [1:0]   op,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] c,
  output logic         sign_c,
  output logic         zero,
  output logic         err
);

`ifdef ULA_PARAM_RADIX4_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int STEPS = (MANT_W + STEP - 1) / STEP;
  localparam int CW    = $clog2(STEPS + 1);
  localparam int PW    = 2 * MANT_W;

  state_e state;
  state_e state_n;

  logic [W-1:0]      ra;
  logic [W-1:0]      rb;
  logic              sa;
  logic              sb;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     mc;
  logic [MANT_W-1:0] mp;
  logic [CW-1:0]     cnt;

  logic [PW-1:0]     acc_n;
  logic [PW-1:0]     mc_n;
  logic [MANT_W-1:0] mp_n;

  logic [W-1:0]      add_c;
  logic              add_s;
  logic [W-1:0]      mul_c;
  logic              mul_s;

  sm_add #(.W(W)) u_add (
    .a      (ra),
    .b      (rb),
    .sign_a (sa),
    .sign_b (sb),
    .c      (add_c),
    .sign_c (add_s)
  );

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // sequencer next state
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          unique case (1'b1)
            (op == OP_MUL): state_n = S_MUL;
            (op == OP_RSV): state_n = S_DONE;
            default:        state_n = S_ADD;
          endcase
        end
      end
      S_ADD:  state_n = S_DONE;
      S_MUL:  if (cnt == '0) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // one shift-add step: STEP multiplier bits retired
  always_comb begin
    acc_n = acc;
    mc_n  = mc;
    mp_n  = mp;
    for (int i = 0; i < STEP; i++) begin
      if (mp_n[0]) acc_n = acc_n + mc_n;
      mc_n = mc_n << 1;
      mp_n = mp_n >> 1;
    end
  end

  assign mul_c = {1'b0, acc_n[PW-1 -: MANT_W+GRD_W], 1'b0};
  assign mul_s = (sa ^ sb) & (|mul_c);

  // operand capture, multiply iteration, result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ra     <= '0;
      rb     <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      acc    <= '0;
      mc     <= '0;
      mp     <= '0;
      cnt    <= '0;
      c      <= '0;
      sign_c <= 1'b0;
      zero   <= 1'b1;
      err    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            ra  <= a;
            rb  <= b;
            sa  <= sign_a;
            sb  <= sign_b ^ (op == OP_SUB);
            acc <= '0;
            mc  <= {{MANT_W{1'b0}}, a[W-3:GRD_W]};
            mp  <= b[W-3:GRD_W];
            cnt <= CW'(STEPS - 1);
            if (op == OP_RSV) begin
              c      <= '0;
              sign_c <= 1'b0;
              zero   <= 1'b1;
              err    <= 1'b1;
            end
          end
        end
        S_ADD: begin
          c      <= add_c;
          sign_c <= add_s;
          zero   <= (add_c == '0);
          err    <= 1'b0;
        end
        S_MUL: begin
          acc <= acc_n;
          mc  <= mc_n;
          mp  <= mp_n;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            c      <= mul_c;
            sign_c <= mul_s;
            zero   <= (mul_c == '0);
            err    <= 1'b0;
          end
        end
        S_DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_param.sv
// Scoreboard bench for ula_param with a behavioural model.
// Driver queues expectations; monitor checks on each done.
module tb_ula_param;

  localparam int MW = 24;
  localparam int GW = 3;
  localparam int W  = MW + GW + 2;
`ifdef ULA_PARAM_RADIX4_EN
  localparam int ML = (MW + 1) / 2 + 1;
`else
  localparam int ML = MW + 1;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sign_a;
  logic         sign_b;
  logic [1:0]   op;
  logic         start;
  logic         busy;
  logic         done;
  logic [W-1:0] c;
  logic         sign_c;
  logic         zero;
  logic         err;

  ula_param #(.MANT_W(MW), .GRD_W(GW)) dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .sign_a (sign_a),
    .sign_b (sign_b),
    .op     (op),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .c      (c),
    .sign_c (sign_c),
    .zero   (zero),
    .err    (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [W-1:0] c;
    logic         s;
    logic         z;
    logic         e;
    int           lat;
    int           t0;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] ex);
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, ex, cyc);
    end
  endtask

  // reference: signed integer arithmetic and a plain product
  function automatic exp_t model(input logic [1:0] o,
                                 input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic s1, input logic s2,
                                 input int t0);
    exp_t e;
    longint va, vb, r;
    longint unsigned ma, mb, p;
    e.t0 = t0;
    e.e  = 1'b0;
    e.c  = '0;
    e.s  = 1'b0;
    if (o == 2'b11) begin
      e.e   = 1'b1;
      e.lat = 1;
    end else if (o == 2'b10) begin
      ma    = longint'(x[W-3:GW]);
      mb    = longint'(y[W-3:GW]);
      p     = ma * mb;
      p     = (p >> (MW - GW)) & ((64'd1 << (MW + GW)) - 1);
      e.c   = W'(p << 1);
      e.s   = s1 ^ s2;
      e.lat = ML;
    end else begin
      va    = longint'(x);
      vb    = longint'(y);
      if (s1) va = -va;
      if (s2 ^ (o == 2'b01)) vb = -vb;
      r     = va + vb;
      e.c   = W'((r < 0) ? -r : r);
      e.s   = (r < 0);
      e.lat = 2;
    end
    if (e.c == '0) e.s = 1'b0;
    e.z = (e.c == '0);
    return e;
  endfunction

  // monitor: every done must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'(0));
      end else begin
        e = q.pop_front();
        chk("c", 64'(c), 64'(e.c));
        chk("sign_c", 64'(sign_c), 64'(e.s));
        chk("zero", 64'(zero), 64'(e.z));
        chk("err", 64'(err), 64'(e.e));
        chk("latency", 64'(cyc - e.t0), 64'(e.lat));
        chk("busy_in_done", 64'(busy), 64'(1));
      end
    end
  end

  task automatic scramble();
    a      = W'($urandom);
    b      = W'($urandom);
    sign_a = 1'($urandom);
    sign_b = 1'($urandom);
    op     = 2'($urandom);
  endtask

  task automatic run(input logic [1:0] o, input logic [W-1:0] x,
                     input logic [W-1:0] y, input logic s1,
                     input logic s2, input bit hold);
    int n;
    @(negedge clk);
    op     = o;
    a      = x;
    b      = y;
    sign_a = s1;
    sign_b = s2;
    start  = 1'b1;
    q.push_back(model(o, x, y, s1, s2, cyc));
    n = 0;
    @(negedge clk);
    while (!done && n < 100) begin
      start = hold;
      scramble();
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 64'(done), 64'(1));
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    logic [W-1:0] v;
    v = W'($urandom);
    if ($urandom_range(0, 1) == 0) v[W-1:W-2] = 2'b00;
    if ($urandom_range(0, 7) == 0) v = '0;
    return v;
  endfunction

  localparam logic [W-1:0] K = 29'h0400_0000;

  initial begin
    logic [W-1:0] x, y;
    reset  = 1'b1;
    start  = 1'b0;
    op     = 2'b00;
    a      = '0;
    b      = '0;
    sign_a = 1'b0;
    sign_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_c", 64'(c), 64'(0));
    chk("rst_sign_c", 64'(sign_c), 64'(0));
    chk("rst_zero", 64'(zero), 64'(1));
    chk("rst_err", 64'(err), 64'(0));
    // reset wins over a simultaneous start
    start = 1'b1;
    op    = 2'b10;
    @(negedge clk);
    chk("rst_prio_busy", 64'(busy), 64'(0));
    start = 1'b0;
    reset = 1'b0;

    run(2'b00, K, K, 1'b0, 1'b0, 1'b0);
    run(2'b01, K, K, 1'b0, 1'b0, 1'b0);
    run(2'b10, K, K, 1'b1, 1'b0, 1'b1);
    run(2'b11, K, K, 1'b0, 1'b0, 1'b0);
    run(2'b00, 29'h0123_4567, 29'h0012_3456, 1'b1, 1'b0, 1'b0);

    // abort a multiply in its tenth cycle, start held throughout
    @(negedge clk);
    op     = 2'b10;
    a      = K;
    b      = K;
    sign_a = 1'b1;
    start  = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_busy_pre", 64'(busy), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_c", 64'(c), 64'(0));
    chk("abort_sign_c", 64'(sign_c), 64'(0));
    chk("abort_zero", 64'(zero), 64'(1));
    chk("abort_err", 64'(err), 64'(0));
    reset = 1'b0;
    start = 1'b0;
    repeat (ML + 5) @(negedge clk);
    chk("abort_idle", 64'(busy), 64'(0));

    for (int i = 0; i < 150; i++) begin
      x = rnd_opnd();
      y = ($urandom_range(0, 9) == 0) ? x : rnd_opnd();
      run(2'($urandom_range(0, 3)), x, y, 1'($urandom),
          1'($urandom), $urandom_range(0, 3) == 0);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ula_param.md
ULA_PARAM -- requirements
Module: ula_param

Interface
REQ-001 SHALL have parameter MANT_W, default 24, mantissa width in bits.
REQ-002 SHALL have parameter GRD_W, default 3, guard/round bits below the mantissa; operand width W = MANT_W+GRD_W+2.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports a, b  input  W  magnitude operands; mantissa at [W-3:GRD_W], guard bits at [GRD_W-1:0], top two bits are carry headroom.
REQ-006 SHALL have ports sign_a, sign_b  input  1  operand signs (1 = negative).
REQ-007 SHALL have port op  input  2  00 add, 01 subtract, 10 multiply, 11 reserved.
REQ-008 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports c (output, W, result magnitude) and sign_c (output, 1, result sign).
REQ-012 SHALL have ports zero (output, 1, c == 0) and err (output, 1, reserved op flagged).

Function
REQ-013 SHALL implement states IDLE, ADD, MUL, DONE; DONE -> IDLE unconditionally after one cycle.
REQ-014 SHALL, in IDLE with start=1, latch a, b, sign_a, sign_b, op at that edge; later input changes SHALL NOT affect the result.
REQ-015 SHALL ignore start outside IDLE; no queuing.
REQ-016 SHALL transition IDLE -> ADD for op 00/01, IDLE -> MUL for op 10, IDLE -> DONE with err=1 and c=0 for op 11.
REQ-017 SHALL treat subtract as add with latched sign_b inverted.
REQ-018 SHALL add sign-magnitude: equal signs -> c = a+b, sign_c = sign_a; unequal -> c = larger minus smaller, sign_c = sign of larger.
REQ-019 SHALL force sign_c = 0 whenever c == 0 (no negative zero).
REQ-020 SHALL multiply the two MANT_W-bit mantissas by shift-add, one multiplier bit per cycle, into a 2*MANT_W-bit accumulator cleared on entry to MUL.
REQ-021 SHALL output c = {1'b0, product[2*MANT_W-1 -: MANT_W+GRD_W], 1'b0} and sign_c = sign_a XOR sign_b for multiply.
REQ-022 SHALL assert done exactly one cycle after the edge that leaves ADD (latency 2 cycles from start) or MUL (latency MANT_W+1 cycles).
REQ-023 SHALL update c, sign_c, zero, err only on entry to DONE and hold them until the next DONE or reset.
REQ-024 SHALL clear err on any non-reserved operation.

Reset
REQ-025 SHALL, with reset high at any edge including mid-operation, go to IDLE and drive c=0, sign_c=0, zero=1, err=0, busy=0, done=0; an aborted operation SHALL NOT pulse done.
REQ-026 SHALL give reset priority over start in the same cycle.

Configuration
REQ-027 SHALL support macro ULA_PARAM_RADIX4_EN: defined -> multiply retires two multiplier bits per cycle, latency ceil(MANT_W/2)+1 cycles; undefined -> radix-2 per REQ-020; product bit-identical in both.

Structure
REQ-028 SHALL place the op encoding and state enumeration in shared package ula_pkg.
REQ-029 SHALL implement the sign-magnitude adder as combinational sub-module sm_add; sequencing and multiplier stay in ula_param.

Verification (MANT_W=24, GRD_W=3, W=29)
REQ-030 SHALL check add: a=b=29'h0400_0000, signs 0, op 00 -> c=29'h0800_0000, sign_c=0, done 2 cycles after start.
REQ-031 SHALL check subtract equal: a=b=29'h0400_0000, op 01 -> c=0, zero=1, sign_c=0.
REQ-032 SHALL check multiply: a=b=29'h0400_0000, sign_a=1, sign_b=0, op 10 -> c=29'h0400_0000, sign_c=1, done 25 cycles after start (13 with ULA_PARAM_RADIX4_EN).
REQ-033 SHALL check reserved: op 11 -> err=1, c=0, done 1 cycle after start; next op 00 clears err.
REQ-034 SHALL check reset at 10th MUL cycle -> IDLE next edge, all outputs at reset values, no done pulse; start held during busy ignored.
